// File: rtl/sram_scan_ctrl.sv
// sram_scan_ctrl: serial scan-chain packet controller for the OpenRAM macro bank.
// A command packet is shifted in, a load edge launches one access, and the read data
// is captured back into the packet so it can be shifted out.
// Optional build macro: SRAM_CHECK_EN adds sticky per-macro read-mismatch flags.
module sram_scan_ctrl #(
    parameter int unsigned NUM_SRAMS   = 12,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WMASK_WIDTH = 4,
    parameter int unsigned READ_LAT    = 1
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            scan_en,
    input  logic                            scan_in,
    output logic                            scan_out,
    input  logic                            sram_load,
    input  logic                            global_csb,
    output logic                            busy,
    output logic                            done,
`ifdef SRAM_CHECK_EN
    output logic [NUM_SRAMS-1:0]            mismatch,
`endif
    output logic [NUM_SRAMS-1:0]            sram_csb,
    output logic                            sram_web,
    output logic [WMASK_WIDTH-1:0]          sram_wmask,
    output logic [ADDR_WIDTH-1:0]           sram_addr,
    output logic [DATA_WIDTH-1:0]           sram_din,
    input  logic [NUM_SRAMS*DATA_WIDTH-1:0] sram_dout
);

    localparam int unsigned SEL_W = 4;

    typedef struct packed {
        logic [SEL_W-1:0]       sel;
        logic [ADDR_WIDTH-1:0]  addr;
        logic [DATA_WIDTH-1:0]  data;
        logic                   csb;
        logic                   web;
        logic [WMASK_WIDTH-1:0] wmask;
    } pkt_t;

    localparam int unsigned PW = $bits(pkt_t);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, CAPTURE} state_t;

    state_t                state;
    pkt_t                  pkt;
    logic                  load_q;
    logic                  acc_en;
    logic                  acc_rd;
    logic [1:0]            wait_cnt;

    logic [NUM_SRAMS-1:0]  sel_oh;
    logic [DATA_WIDTH-1:0] dout_sel;
    logic                  load_rise;
    logic                  acc_go;

    // The packet MSB is a flop, so scan_out is glitch-free even though it is a plain assign.
    assign scan_out  = pkt.sel[SEL_W-1];
    assign load_rise = sram_load & ~load_q;
    // An out-of-range sel decodes to an all-zero one-hot, which also suppresses the access.
    assign acc_go    = ~pkt.csb & ~global_csb & (|sel_oh);

    // Decode sel into a one-hot macro select and pick that macro's read data.
    always_comb begin
        sel_oh   = '0;
        dout_sel = '0;
        for (int i = 0; i < int'(NUM_SRAMS); i++) begin
            if (pkt.sel == SEL_W'(i)) begin
                sel_oh[i] = 1'b1;
                dout_sel  = sram_dout[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Shift/access FSM with all SRAM-side outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            pkt        <= '0;
            load_q     <= 1'b0;
            acc_en     <= 1'b0;
            acc_rd     <= 1'b0;
            wait_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sram_csb   <= '1;
            sram_web   <= 1'b1;
            sram_wmask <= '0;
            sram_addr  <= '0;
            sram_din   <= '0;
`ifdef SRAM_CHECK_EN
            mismatch   <= '0;
`endif
        end else begin
            load_q <= sram_load;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    // Scan has priority over a coincident load edge.
                    if (scan_en) begin
                        pkt <= pkt_t'({pkt[PW-2:0], scan_in});
                    end else if (load_rise) begin
                        state      <= ACCESS;
                        busy       <= 1'b1;
                        sram_csb   <= ~(sel_oh & {NUM_SRAMS{acc_go}});
                        sram_web   <= pkt.web;
                        sram_wmask <= pkt.wmask;
                        sram_addr  <= pkt.addr;
                        sram_din   <= pkt.data;
                        acc_en     <= acc_go;
                        acc_rd     <= pkt.web;
                    end
                end
                ACCESS: begin
                    sram_csb <= '1;
                    if (READ_LAT <= 1) begin
                        state <= CAPTURE;
                        done  <= 1'b1;
                    end else begin
                        state    <= WAIT;
                        wait_cnt <= 2'(READ_LAT - 2);
                    end
                end
                WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= CAPTURE;
                        done  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                CAPTURE: begin
                    if (acc_en && acc_rd) begin
                        pkt.data <= dout_sel;
`ifdef SRAM_CHECK_EN
                        if (dout_sel != pkt.data) begin
                            mismatch <= mismatch | sel_oh;
                        end
`endif
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_scan_ctrl.sv
// tb_sram_scan_ctrl: directed bench for sram_scan_ctrl with READ_LAT=1 and READ_LAT=3
// instances sharing stimulus, each backed by a small behavioural SRAM bank.
// Define SRAM_CHECK_EN to also exercise the mismatch flags.
module tb_sram_scan_ctrl;

    localparam int unsigned NS = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned PW = 58;

    logic clk;
    logic resetn;
    logic scan_en;
    logic scan_in;
    logic sram_load;
    logic global_csb;

    logic              scan_out1, busy1, done1, web1;
    logic [NS-1:0]     csb1;
    logic [3:0]        wmask1;
    logic [15:0]       addr1;
    logic [DW-1:0]     din1;
    logic [NS*DW-1:0]  dout1;

    logic              scan_out3, busy3, done3, web3;
    logic [NS-1:0]     csb3;
    logic [3:0]        wmask3;
    logic [15:0]       addr3;
    logic [DW-1:0]     din3;
    logic [NS*DW-1:0]  dout3;

`ifdef SRAM_CHECK_EN
    logic [NS-1:0]     mm1, mm3;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    sram_scan_ctrl #(.READ_LAT(1)) dut1 (
        .clk(clk), .resetn(resetn), .scan_en(scan_en), .scan_in(scan_in),
        .scan_out(scan_out1), .sram_load(sram_load), .global_csb(global_csb),
        .busy(busy1), .done(done1),
`ifdef SRAM_CHECK_EN
        .mismatch(mm1),
`endif
        .sram_csb(csb1), .sram_web(web1), .sram_wmask(wmask1),
        .sram_addr(addr1), .sram_din(din1), .sram_dout(dout1)
    );

    sram_scan_ctrl #(.READ_LAT(3)) dut3 (
        .clk(clk), .resetn(resetn), .scan_en(scan_en), .scan_in(scan_in),
        .scan_out(scan_out3), .sram_load(sram_load), .global_csb(global_csb),
        .busy(busy3), .done(done3),
`ifdef SRAM_CHECK_EN
        .mismatch(mm3),
`endif
        .sram_csb(csb3), .sram_web(web3), .sram_wmask(wmask3),
        .sram_addr(addr3), .sram_din(din3), .sram_dout(dout3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM banks: 16 words per macro, indexed by addr[3:0].
    logic [DW-1:0] mem1 [NS][16];
    logic [DW-1:0] mem3 [NS][16];
    logic [DW-1:0] rd1  [NS];
    logic [DW-1:0] rd3a [NS];
    logic [DW-1:0] rd3b [NS];
    logic [DW-1:0] rd3c [NS];

    function automatic logic [DW-1:0] preset(input int i, input int j);
        if (i == 9 && j == 0) return 32'h1;
        return {8'(i), 8'(j), 16'hC0DE};
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < int'(NS); i++) begin
            if (!resetn) begin
                for (int j = 0; j < 16; j++) begin
                    mem1[i][j] <= preset(i, j);
                    mem3[i][j] <= preset(i, j);
                end
            end else begin
                if (!csb1[i]) begin
                    if (!web1) begin
                        for (int b = 0; b < 4; b++)
                            if (wmask1[b]) mem1[i][addr1[3:0]][8*b +: 8] <= din1[8*b +: 8];
                    end else begin
                        rd1[i] <= mem1[i][addr1[3:0]];
                    end
                end
                if (!csb3[i]) begin
                    if (!web3) begin
                        for (int b = 0; b < 4; b++)
                            if (wmask3[b]) mem3[i][addr3[3:0]][8*b +: 8] <= din3[8*b +: 8];
                    end else begin
                        rd3a[i] <= mem3[i][addr3[3:0]];
                    end
                end
            end
            rd3b[i] <= rd3a[i];
            rd3c[i] <= rd3b[i];
        end
    end

    for (genvar g = 0; g < int'(NS); g++) begin : g_dout
        assign dout1[g*DW +: DW] = rd1[g];
        assign dout3[g*DW +: DW] = rd3c[g];
    end

    always @(posedge clk) if (done1) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk(input logic [3:0] s, input logic [15:0] a,
                                         input logic [31:0] d, input logic c,
                                         input logic w, input logic [3:0] m);
        return {s, a, d, c, w, m};
    endfunction

    task automatic shift_pkt(input logic [PW-1:0] pkt);
        for (int i = PW - 1; i >= 0; i--) begin
            @(negedge clk);
            scan_en = 1'b1;
            scan_in = pkt[i];
        end
        @(negedge clk);
        scan_en = 1'b0;
        scan_in = 1'b0;
    endtask

    task automatic read_pkt(output logic [PW-1:0] got1, output logic [PW-1:0] got3);
        for (int i = PW - 1; i >= 0; i--) begin
            @(negedge clk);
            got1[i] = scan_out1;
            got3[i] = scan_out3;
            scan_en = 1'b1;
            scan_in = 1'b0;
        end
        @(negedge clk);
        scan_en = 1'b0;
    endtask

    // Launch one access and check csb/busy/done timing on both latency variants.
    task automatic run_load(input string tag, input logic [NS-1:0] exp_csb,
                            input bit hold, input bit poke);
        @(negedge clk);
        sram_load = 1'b1;
        @(negedge clk);
        check({tag, "_csb1"}, 64'(csb1), 64'(exp_csb));
        check({tag, "_csb3"}, 64'(csb3), 64'(exp_csb));
        check({tag, "_busy1"}, 64'(busy1), 64'd1);
        check({tag, "_done1_early"}, 64'(done1), 64'd0);
        if (poke) begin
            scan_en = 1'b1;
            scan_in = 1'b1;
        end
        if (!hold) sram_load = 1'b0;
        @(negedge clk);
        check({tag, "_csb1_off"}, 64'(csb1), 64'hFFF);
        check({tag, "_done1"}, 64'(done1), 64'd1);
        check({tag, "_done3_early"}, 64'(done3), 64'd0);
        @(negedge clk);
        scan_en = 1'b0;
        scan_in = 1'b0;
        check({tag, "_done1_clr"}, 64'(done1), 64'd0);
        check({tag, "_busy1_clr"}, 64'(busy1), 64'd0);
        check({tag, "_busy3"}, 64'(busy3), 64'd1);
        @(negedge clk);
        check({tag, "_done3"}, 64'(done3), 64'd1);
        @(negedge clk);
        check({tag, "_done3_clr"}, 64'(done3), 64'd0);
        check({tag, "_busy3_clr"}, 64'(busy3), 64'd0);
        sram_load = 1'b0;
    endtask

    logic [PW-1:0] r1, r3;
    int            dc;

    initial begin
        resetn     = 1'b0;
        scan_en    = 1'b0;
        scan_in    = 1'b0;
        sram_load  = 1'b0;
        global_csb = 1'b0;
        @(negedge clk);
        check("rst_csb", 64'(csb1), 64'hFFF);
        check("rst_busy", 64'(busy1), 64'd0);
        check("rst_done", 64'(done1), 64'd0);
        check("rst_web", 64'(web1), 64'd1);
        check("rst_addr_din", {16'(addr1), din1}, 64'd0);
        check("rst_scan_out", 64'(scan_out1), 64'd0);
`ifdef SRAM_CHECK_EN
        check("rst_mismatch", 64'(mm1), 64'd0);
`endif
        @(negedge clk);
        resetn = 1'b1;

        // Asynchronous reset after filling the packet with ones.
        shift_pkt({PW{1'b1}});
        check("fill_scan_out", 64'(scan_out1), 64'd1);
        #2 resetn = 1'b0;
        #1;
        check("arst_scan_out", 64'(scan_out1), 64'd0);
        check("arst_csb", 64'(csb1), 64'hFFF);
        check("arst_busy", 64'(busy1), 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        read_pkt(r1, r3);
        check("arst_pkt", 64'(r1), 64'd0);

        // Write DEADBEEF to macro 2, then read it back.
        shift_pkt(mk(4'd2, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b0, 4'hF));
        run_load("wr2", 12'hFFB, 1'b0, 1'b0);
        check("wr2_din_hold", 64'(din1), 64'hDEADBEEF);
        check("wr2_addr_hold", 64'(addr1), 64'h0010);
        check("wr2_web_hold", 64'(web1), 64'd0);
        check("wr2_wmask_hold", 64'(wmask1), 64'hF);
        shift_pkt(mk(4'd2, 16'h0010, 32'h0, 1'b0, 1'b1, 4'hF));
        run_load("rd2", 12'hFFB, 1'b0, 1'b0);
        read_pkt(r1, r3);
        check("rd2_pkt1", 64'(r1), 64'(mk(4'd2, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b1, 4'hF)));
        check("rd2_pkt3", 64'(r3), 64'(mk(4'd2, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b1, 4'hF)));

        // global_csb suppresses a valid read: no capture.
        global_csb = 1'b1;
        shift_pkt(mk(4'd0, 16'h0000, 32'h12345678, 1'b0, 1'b1, 4'hF));
        run_load("gcsb", 12'hFFF, 1'b0, 1'b0);
        global_csb = 1'b0;
        read_pkt(r1, r3);
        check("gcsb_pkt1", 64'(r1), 64'(mk(4'd0, 16'h0000, 32'h12345678, 1'b0, 1'b1, 4'hF)));
        check("gcsb_pkt3", 64'(r3), 64'(mk(4'd0, 16'h0000, 32'h12345678, 1'b0, 1'b1, 4'hF)));

        // Out-of-range sel with load held high for five cycles: one suppressed access.
        shift_pkt(mk(4'hF, 16'h0001, 32'hCAFEF00D, 1'b0, 1'b1, 4'hF));
        dc = done_cnt;
        run_load("self", 12'hFFF, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        check("self_one_access", 64'(done_cnt), 64'(dc + 1));
        read_pkt(r1, r3);
        check("self_pkt", 64'(r1), 64'(mk(4'hF, 16'h0001, 32'hCAFEF00D, 1'b0, 1'b1, 4'hF)));

        // Read macro 1 with scan_en pulsed while busy: shifts are ignored, data captured.
        shift_pkt(mk(4'd1, 16'h0003, 32'h0, 1'b0, 1'b1, 4'hF));
        run_load("poke", 12'hFFD, 1'b0, 1'b1);
        read_pkt(r1, r3);
        check("poke_pkt1", 64'(r1), 64'(mk(4'd1, 16'h0003, 32'h0103C0DE, 1'b0, 1'b1, 4'hF)));
        check("poke_pkt3", 64'(r3), 64'(mk(4'd1, 16'h0003, 32'h0103C0DE, 1'b0, 1'b1, 4'hF)));

        // Scan and load edge in the same cycle: one shift, no access.
        dc = done_cnt;
        @(negedge clk);
        sram_load = 1'b1;
        scan_en   = 1'b1;
        scan_in   = 1'b1;
        @(negedge clk);
        scan_en = 1'b0;
        scan_in = 1'b0;
        check("scanwin_busy", 64'(busy1), 64'd0);
        check("scanwin_csb", 64'(csb1), 64'hFFF);
        repeat (5) @(negedge clk);
        check("scanwin_no_done", 64'(done_cnt), 64'(dc));
        sram_load = 1'b0;
        read_pkt(r1, r3);
        check("scanwin_pkt1", 64'(r1), 64'd1);
        check("scanwin_pkt3", 64'(r3), 64'd1);

        // Macro 9 holds 1 at word 0: a read expecting 0 then one expecting 1.
        shift_pkt(mk(4'd9, 16'h0000, 32'h0, 1'b0, 1'b1, 4'hF));
        run_load("rd9a", 12'hDFF, 1'b0, 1'b0);
`ifdef SRAM_CHECK_EN
        check("mm_set1", 64'(mm1), 64'h200);
        check("mm_set3", 64'(mm3), 64'h200);
`endif
        shift_pkt(mk(4'd9, 16'h0000, 32'h1, 1'b0, 1'b1, 4'hF));
        run_load("rd9b", 12'hDFF, 1'b0, 1'b0);
`ifdef SRAM_CHECK_EN
        check("mm_sticky1", 64'(mm1), 64'h200);
        check("mm_sticky3", 64'(mm3), 64'h200);
`endif
        read_pkt(r1, r3);
        check("rd9b_pkt", 64'(r1), 64'(mk(4'd9, 16'h0000, 32'h1, 1'b0, 1'b1, 4'hF)));

        // Reset in the middle of an access releases chip selects immediately.
        shift_pkt(mk(4'd3, 16'h0000, 32'h0, 1'b0, 1'b1, 4'hF));
        @(negedge clk);
        sram_load = 1'b1;
        @(negedge clk);
        check("midrst_csb_on", 64'(csb1), 64'hFF7);
        #2 resetn = 1'b0;
        #1;
        check("midrst_csb", 64'(csb1), 64'hFFF);
        check("midrst_csb3", 64'(csb3), 64'hFFF);
        check("midrst_busy", 64'(busy1), 64'd0);
        sram_load = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_idle", {63'd0, busy3}, 64'd0);
        read_pkt(r1, r3);
        check("midrst_pkt", 64'(r1), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_scan_ctrl.md
Name: sram_scan_ctrl

Overview:
- Serial scan-chain packet controller between the GPIO pins (gpio_clk / gpio_in / gpio_scan / gpio_sram_load / global_csb / gpio_out) and the OpenRAM macro bank.
- Shifts in a command packet, issues one SRAM access to the selected macro on a load request, then captures the read data back into the packet so it can be shifted out.
- Directly upstream of the SRAM macros; its read-back data feeds the per-SRAM mismatch flags.

Parameters:
- NUM_SRAMS, 12, number of macros addressed; sel field width is 4.
- ADDR_WIDTH, 16, address field width.
- DATA_WIDTH, 32, din/dout width.
- WMASK_WIDTH, 4, write-mask width; one bit per byte.
- READ_LAT, 1, cycles from the access cycle to valid dout, 1..3.

Ports:
- clk  in  1  gpio_clk domain; all logic on posedge.
- resetn  in  1  asynchronous, active-low reset.
- scan_en  in  1  gpio_scan; shift enable.
- scan_in  in  1  gpio_in; serial data, MSB first.
- scan_out  out  1  gpio_out; packet MSB.
- sram_load  in  1  gpio_sram_load; level, rising edge starts an access.
- global_csb  in  1  high blocks all SRAM access.
- busy  out  1  access in progress.
- done  out  1  one-cycle pulse when an access completes.
- sram_csb  out  NUM_SRAMS  per-macro chip select, active-low.
- sram_web  out  1  write enable, active-low.
- sram_wmask  out  WMASK_WIDTH  byte mask.
- sram_addr  out  ADDR_WIDTH  address.
- sram_din  out  DATA_WIDTH  write data.
- sram_dout  in  NUM_SRAMS*DATA_WIDTH  flattened read data; macro i at [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Packet register P, PW = 4+ADDR_WIDTH+DATA_WIDTH+2+WMASK_WIDTH = 58 bits by default.
- Field order, MSB to LSB: sel[3:0], addr, data, csb, web, wmask.
- Reset: P=0, FSM=IDLE, busy=0, done=0, sram_csb all 1, sram_web=1, and sram_wmask, sram_addr and sram_din all 0. The load edge detector clears.
- Reset is asynchronous. Asserting it mid-access forces sram_csb all 1 immediately, with no partial capture.
- Shift: in IDLE with scan_en=1, each cycle P <= {P[PW-2:0], scan_in}. scan_out = P[PW-1] combinationally.
- scan_en is ignored while busy=1.
- Load detect: a registered sram_load, rising edge only. It is ignored when scan_en=1 in the same cycle, because scan wins. It is also ignored while busy.
- FSM states: IDLE -> ACCESS -> WAIT -> CAPTURE -> IDLE.
  - IDLE: a load edge moves to ACCESS and sets busy=1.
  - ACCESS, 1 cycle: the sram_* outputs take the P fields. sram_csb[sel] = P.csb; every other bit is 1.
  - ACCESS, suppression: if global_csb=1 or sel>=NUM_SRAMS, all sram_csb stay 1.
  - WAIT: lasts READ_LAT-1 cycles, so 0 cycles when READ_LAT=1. All sram_csb are 1.
  - CAPTURE, 1 cycle: if the access was enabled (csb=0, not suppressed) and web=1, P.data <= sram_dout[sel]. Otherwise P is unchanged. done=1, busy is cleared at the next edge, and the FSM returns to IDLE.
- Latency: load edge seen at cycle T; ACCESS at T+1; CAPTURE/done at T+1+READ_LAT.
- Writes (web=0): the access happens, nothing is captured, done still pulses.
- sram_addr, sram_din, sram_web and sram_wmask hold their last driven values outside ACCESS. Only csb gates the macros.

Optional Feature:
- Macro: SRAM_CHECK_EN.
- Enabled:
  - Adds output mismatch[NUM_SRAMS-1:0], which resets to 0.
  - In CAPTURE of an enabled read, if sram_dout[sel] != the pre-capture P.data (the expected value shifted in), mismatch[sel] is set.
  - mismatch bits are sticky until resetn.
  - Suppressed accesses and writes never set a flag.
- Disabled: no mismatch port and no compare logic.

Test Plan:
- Reset: resetn=0 mid-shift -> sram_csb=12'hFFF, busy=0, scan_out=0. P reads all zeros after release.
- Write then read, sel=2:
  - Shift a write packet (sel=2, addr=16'h0010, data=32'hDEADBEEF, csb=0, web=0, wmask=4'hF), pulse load -> sram_csb=12'hFFB for exactly 1 cycle at T+1 with sram_din=32'hDEADBEEF; done at T+2.
  - Then shift a read packet to the same address, load, shift out 58 bits -> data field = 32'hDEADBEEF.
- global_csb=1 with a valid read to sel=0 -> sram_csb stays 12'hFFF, done pulses, P unchanged on shift-out.
- sel=4'hF -> no csb asserted, done pulses at T+2. Also hold sram_load high for 5 cycles -> exactly one access.
- READ_LAT=3 -> done at T+4. scan_en pulsed during busy -> P unchanged. scan_en=1 together with a load edge -> no access, 1 shift.
- SRAM_CHECK_EN: read sel=9 with expected 32'h0 while the model returns 32'h1 -> mismatch=12'h200, still set after a later matching read. Compiled out -> no mismatch port.
